pb_sr_debounce: RTL and testbench

Front-end conditioning stage that feeds the set/reset inputs of the SR flop with asynchronous active-low reset. Takes two raw, bouncy, asynchronous active-low push-button inputs (set and reset buttons), synchronizes each through a two-flop synchronizer, debounces it with a per-channel counter FSM, and emits a clean one-cycle `s`/`r` pulse plus a debounced level per channel. Both channels are identical, independent instances of the same logic inside the module.

---
 rtl/pb_sr_debounce.sv | 132 +++++++++++++
 tb/tb_pb_sr_debounce.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pb_sr_debounce.sv
// pb_sr_debounce: synchronizes and debounces two active-low push buttons into clean s/r pulses and levels
// Optional feature macro: PB_RELEASE_PULSE_EN enables the s_rel/r_rel release pulses.
module pb_sr_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn_n,
    input  logic rst_btn_n,
    output logic s,
    output logic r,
    output logic s_lvl,
    output logic r_lvl,
    output logic s_rel,
    output logic r_rel
);
    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0] btn_n;
    logic [1:0] press_pulse;
    logic [1:0] rel_pulse;
    logic [1:0] lvl;

    assign btn_n = {rst_btn_n, set_btn_n};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic             sync1_q, sync2_q, pressed;
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d, press_q, press_d;

        // two-flop synchronizer, reset to released so reset exit never looks like a press
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= btn_n[c];
                sync2_q <= sync1_q;
            end
        end

        assign pressed = ~sync2_q;

        // debounce FSM: a level change is accepted after DB_CYCLES further stable samples
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                RELEASED: begin
                    if (pressed) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed)
                        state_d = RELEASED;
                    else if (cnt_q == CNT_LAST)
                        state_d = PRESSED;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
                PRESSED: begin
                    if (!pressed) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (pressed)
                        state_d = PRESSED;
                    else if (cnt_q == CNT_LAST)
                        state_d = RELEASED;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
            endcase
        end

        assign press_d = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        assign lvl_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

        // FSM state, counter, registered level and press pulse
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                press_q <= press_d;
            end
        end

        assign press_pulse[c] = press_q;
        assign lvl[c]         = lvl_q;

`ifdef PB_RELEASE_PULSE_EN
        logic rel_q, rel_d;

        assign rel_d = (state_q == RELEASE_WAIT) && (state_d == RELEASED);

        // registered release pulse, aligned with the level falling
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                rel_q <= 1'b0;
            else
                rel_q <= rel_d;
        end

        assign rel_pulse[c] = rel_q;
`else
        assign rel_pulse[c] = 1'b0;
`endif
    end

    assign s     = press_pulse[0];
    assign r     = press_pulse[1];
    assign s_lvl = lvl[0];
    assign r_lvl = lvl[1];
    assign s_rel = rel_pulse[0];
    assign r_rel = rel_pulse[1];
endmodule

// File: tb/tb_pb_sr_debounce.sv
// tb_pb_sr_debounce: directed checks of pb_sr_debounce at DB_CYCLES of 4, 8 and 31
module tb_pb_sr_debounce;
`ifdef PB_RELEASE_PULSE_EN
    localparam logic REL_EN = 1'b1;
`else
    localparam logic REL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic set_btn_n = 1'b1;
    logic rst_btn_n = 1'b1;
    logic s4, r4, sl4, rl4, sr4, rr4;
    logic s8, r8, sl8, rl8, sr8, rr8;
    logic s31, r31, sl31, rl31, sr31, rr31;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pb_sr_debounce #(.DB_CYCLES(4), .CNT_W(5)) u4 (
        .clk(clk), .rst_n(rst_n), .set_btn_n(set_btn_n), .rst_btn_n(rst_btn_n),
        .s(s4), .r(r4), .s_lvl(sl4), .r_lvl(rl4), .s_rel(sr4), .r_rel(rr4)
    );

    pb_sr_debounce #(.DB_CYCLES(8), .CNT_W(5)) u8 (
        .clk(clk), .rst_n(rst_n), .set_btn_n(set_btn_n), .rst_btn_n(rst_btn_n),
        .s(s8), .r(r8), .s_lvl(sl8), .r_lvl(rl8), .s_rel(sr8), .r_rel(rr8)
    );

    pb_sr_debounce #(.DB_CYCLES(31), .CNT_W(5)) u31 (
        .clk(clk), .rst_n(rst_n), .set_btn_n(set_btn_n), .rst_btn_n(rst_btn_n),
        .s(s31), .r(r31), .s_lvl(sl31), .r_lvl(rl31), .s_rel(sr31), .r_rel(rr31)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_btn_n = 1'b1;
        rst_btn_n = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_s", s4, 1'b0);
        chk("rst_r", r4, 1'b0);
        chk("rst_s_lvl", sl4, 1'b0);
        chk("rst_r_lvl", rl4, 1'b0);
        chk("rst_s_rel", sr4, 1'b0);
        chk("rst_r_rel", rr4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // clean press held long enough for all three instances, DB31 covers the counter bound
        set_btn_n = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("press_s4@%0d", i), s4, i == 6);
            chk($sformatf("press_sl4@%0d", i), sl4, i >= 6);
            chk($sformatf("press_r4@%0d", i), r4, 1'b0);
            chk($sformatf("press_rl4@%0d", i), rl4, 1'b0);
            chk($sformatf("press_sr4@%0d", i), sr4, 1'b0);
            chk($sformatf("press_s8@%0d", i), s8, i == 10);
            chk($sformatf("press_s31@%0d", i), s31, i == 33);
            chk($sformatf("press_sl31@%0d", i), sl31, i >= 33);
        end

        // release after a long hold
        set_btn_n = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rel_sr4@%0d", i), sr4, REL_EN && i == 6);
            chk($sformatf("rel_sl4@%0d", i), sl4, i < 6);
            chk($sformatf("rel_s4@%0d", i), s4, 1'b0);
            chk($sformatf("rel_rr4@%0d", i), rr4, 1'b0);
            chk($sformatf("rel_sr8@%0d", i), sr8, REL_EN && i == 10);
            chk($sformatf("rel_sl8@%0d", i), sl8, i < 10);
            chk($sformatf("rel_sl31@%0d", i), sl31, i < 33);
        end

        // bounce for 12 cycles, then stable press from edge 12
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            set_btn_n = (k < 12) ? logic'((k / 2) % 2) : 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bounce_s4@%0d", k), s4, k == 18);
            chk($sformatf("bounce_sl4@%0d", k), sl4, k >= 18);
            chk($sformatf("bounce_s8@%0d", k), s8, k == 22);
        end

        // simultaneous presses, then asynchronous reset with both levels high
        do_reset();
        set_btn_n = 1'b0;
        rst_btn_n = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("both_s4@%0d", i), s4, i == 6);
            chk($sformatf("both_r4@%0d", i), r4, i == 6);
            chk($sformatf("both_sl4@%0d", i), sl4, i >= 6);
            chk($sformatf("both_rl4@%0d", i), rl4, i >= 6);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_sl4", sl4, 1'b0);
        chk("async_rl4", rl4, 1'b0);
        chk("async_sl8", sl8, 1'b0);

        // reset during qualification with the button still held
        do_reset();
        set_btn_n = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("midq_s8@%0d", i), s8, 1'b0);
            chk($sformatf("midq_s4@%0d", i), s4, 1'b0);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midq_rst_s8", s8, 1'b0);
        chk("midq_rst_sl8", sl8, 1'b0);
        @(negedge clk);
        chk("midq_hold_s4", s4, 1'b0);
        @(negedge clk);
        chk("midq_hold_s4b", s4, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("requal_s8@%0d", j), s8, j == 10);
            chk($sformatf("requal_sl8@%0d", j), sl8, j >= 10);
            chk($sformatf("requal_s4@%0d", j), s4, j == 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
